// File: rtl/ram_arb_pkg.sv
// Shared types and widths for the three-port SRAM arbiter.
package ram_arb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned BE_W  = 4;
    localparam int unsigned AGE_W = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_INSTR,
        OWN_DATA,
        OWN_CUST
    } owner_e;

    typedef struct packed {
        owner_e owner;
        logic   err;
    } pending_t;

    typedef struct packed {
        logic            we;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/ram_arb_age_ctr.sv
// Saturating wait counter; promote_c flags a requestor that has waited MAX_WAIT cycles.
module ram_arb_age_ctr
    import ram_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_i,
    input  logic gnt_i,
    output logic promote_c
);

    localparam logic [AGE_W-1:0] MAX_CNT = AGE_W'(MAX_WAIT);

    logic [AGE_W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (!req_i || gnt_i) begin
            cnt_d = '0;
        end else if (cnt_q != MAX_CNT) begin
            cnt_d = cnt_q + AGE_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign promote_c = (cnt_q == MAX_CNT);

endmodule

// File: rtl/ram_arbiter_3p.sv
// Arbitrates instr fetch, LSU and custom-unit requests onto the single-port SRAM,
// with same-cycle grant, one-cycle response routing and age-based promotion.
module ram_arbiter_3p
    import ram_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE  = 262144,
    parameter logic [31:0] MEM_START = 32'h0000_0000,
    parameter int unsigned MAX_WAIT  = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    output logic              instr_gnt_o,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,
    output logic              instr_err_o,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_gnt_o,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,
    output logic              data_err_o,
    input  logic              cust_req_i,
    input  logic              cust_we_i,
    input  logic [XLEN-1:0]   cust_addr_i,
    input  logic [XLEN-1:0]   cust_wdata_i,
    output logic              cust_gnt_o,
    output logic              cust_rvalid_o,
    output logic [XLEN-1:0]   cust_rdata_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [BE_W-1:0]   mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam logic [XLEN-1:0] ADDR_MASK = ~(XLEN'(MEM_SIZE) - XLEN'(1));

    owner_e   winner;
    mem_cmd_t cmd;
    logic     in_range;
    logic     issue;
    logic     data_promote, cust_promote;
    pending_t pend_d, pend_q;

    ram_arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_data_age (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (data_req_i),
        .gnt_i     (data_gnt_o),
        .promote_c (data_promote)
    );

    ram_arb_age_ctr #(.MAX_WAIT(MAX_WAIT)) u_cust_age (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (cust_req_i),
        .gnt_i     (cust_gnt_o),
        .promote_c (cust_promote)
    );

    // Winner selection: starved ports jump ahead of fetch; nothing is granted in reset.
    always_comb begin
        winner = OWN_NONE;
        if (rst_ni) begin
            if (data_req_i && data_promote)      winner = OWN_DATA;
            else if (cust_req_i && cust_promote) winner = OWN_CUST;
            else if (instr_req_i)                winner = OWN_INSTR;
            else if (data_req_i)                 winner = OWN_DATA;
            else if (cust_req_i)                 winner = OWN_CUST;
        end
    end

    always_comb begin
        cmd = '0;
        case (winner)
            OWN_INSTR: cmd = '{we: 1'b0, be: 4'hF, addr: instr_addr_i, wdata: '0};
            OWN_DATA:  cmd = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
            OWN_CUST:  cmd = '{we: cust_we_i, be: 4'hF, addr: cust_addr_i, wdata: cust_wdata_i};
            default:   cmd = '0;
        endcase
        in_range = ((cmd.addr & ADDR_MASK) == MEM_START);
        issue    = (winner != OWN_NONE) && in_range;
        pend_d   = '{owner: winner, err: (winner != OWN_NONE) && !in_range};
    end

    assign instr_gnt_o = (winner == OWN_INSTR);
    assign data_gnt_o  = (winner == OWN_DATA);
    assign cust_gnt_o  = (winner == OWN_CUST);

    // Out-of-range winners are granted but never reach the SRAM.
    assign mem_req_o   = issue;
    assign mem_we_o    = issue & cmd.we;
    assign mem_be_o    = issue ? cmd.be    : '0;
    assign mem_addr_o  = issue ? cmd.addr  : '0;
    assign mem_wdata_o = issue ? cmd.wdata : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= '{owner: OWN_NONE, err: 1'b0};
        end else begin
            pend_q <= pend_d;
        end
    end

    assign instr_rvalid_o = (pend_q.owner == OWN_INSTR);
    assign data_rvalid_o  = (pend_q.owner == OWN_DATA);
    assign cust_rvalid_o  = (pend_q.owner == OWN_CUST);
    assign instr_err_o    = instr_rvalid_o & pend_q.err;
    assign data_err_o     = data_rvalid_o & pend_q.err;
    assign instr_rdata_o  = (instr_rvalid_o && !pend_q.err) ? mem_rdata_i : '0;
    assign data_rdata_o   = (data_rvalid_o && !pend_q.err) ? mem_rdata_i : '0;
    assign cust_rdata_o   = (cust_rvalid_o && !pend_q.err) ? mem_rdata_i : '0;

    mem_rvalid_chk: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i == ((pend_q.owner != OWN_NONE) && !pend_q.err));

endmodule

// File: tb/tb_ram_arbiter_3p.sv
// Directed table-driven bench for ram_arbiter_3p with a one-cycle-latency SRAM model.
module tb_ram_arbiter_3p;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        cust_req, cust_we, cust_gnt, cust_rvalid;
    logic [31:0] cust_addr, cust_wdata, cust_rdata;
    logic        mem_req, mem_we, mem_rvalid;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    ram_arbiter_3p dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .instr_req_i    (instr_req),
        .instr_addr_i   (instr_addr),
        .instr_gnt_o    (instr_gnt),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .instr_err_o    (instr_err),
        .data_req_i     (data_req),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_addr_i    (data_addr),
        .data_wdata_i   (data_wdata),
        .data_gnt_o     (data_gnt),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .cust_req_i     (cust_req),
        .cust_we_i      (cust_we),
        .cust_addr_i    (cust_addr),
        .cust_wdata_i   (cust_wdata),
        .cust_gnt_o     (cust_gnt),
        .cust_rvalid_o  (cust_rvalid),
        .cust_rdata_o   (cust_rdata),
        .mem_req_o      (mem_req),
        .mem_we_o       (mem_we),
        .mem_be_o       (mem_be),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_rvalid_i   (mem_rvalid),
        .mem_rdata_i    (mem_rdata)
    );

    // SRAM stand-in: returns addr ^ 0x5A5A0000 one cycle after each request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rvalid <= 1'b0;
            mem_rdata  <= '0;
        end else begin
            mem_rvalid <= mem_req;
            mem_rdata  <= mem_req ? (mem_addr ^ 32'h5A5A_0000) : 32'h0;
        end
    end

    typedef struct {
        logic        ireq;  logic [31:0] iaddr;
        logic        dreq;  logic dwe; logic [3:0] dbe; logic [31:0] daddr; logic [31:0] dwdata;
        logic        creq;  logic cwe; logic [31:0] caddr; logic [31:0] cwdata;
        logic [2:0]  gnt;   // {instr, data, cust}
        logic        mreq;  logic mwe; logic [3:0] mbe; logic [31:0] maddr; logic [31:0] mwdata;
        logic [2:0]  rv;    // {instr, data, cust}
        logic [1:0]  err;   // {instr, data}
        logic [31:0] rdata;
    } vec_t;

    function automatic vec_t mkv(
        input logic ireq, input logic [31:0] iaddr,
        input logic dreq, input logic dwe, input logic [3:0] dbe, input logic [31:0] daddr, input logic [31:0] dwdata,
        input logic creq, input logic cwe, input logic [31:0] caddr, input logic [31:0] cwdata,
        input logic [2:0] gnt, input logic mreq, input logic mwe, input logic [3:0] mbe,
        input logic [31:0] maddr, input logic [31:0] mwdata,
        input logic [2:0] rv, input logic [1:0] err, input logic [31:0] rdata);
        vec_t v;
        v.ireq = ireq; v.iaddr = iaddr;
        v.dreq = dreq; v.dwe = dwe; v.dbe = dbe; v.daddr = daddr; v.dwdata = dwdata;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwdata = cwdata;
        v.gnt = gnt; v.mreq = mreq; v.mwe = mwe; v.mbe = mbe; v.maddr = maddr; v.mwdata = mwdata;
        v.rv = rv; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive one vector's inputs, let combinational paths settle, compare everything.
    task automatic run(input vec_t v, input string tag);
        instr_req = v.ireq; instr_addr = v.iaddr;
        data_req = v.dreq; data_we = v.dwe; data_be = v.dbe; data_addr = v.daddr; data_wdata = v.dwdata;
        cust_req = v.creq; cust_we = v.cwe; cust_addr = v.caddr; cust_wdata = v.cwdata;
        #1;
        n_vec++;
        chk({tag, " gnt"},       32'({instr_gnt, data_gnt, cust_gnt}), 32'(v.gnt));
        chk({tag, " mem_req"},   32'(mem_req), 32'(v.mreq));
        chk({tag, " mem_we"},    32'(mem_we), 32'(v.mwe));
        chk({tag, " mem_be"},    32'(mem_be), 32'(v.mbe));
        chk({tag, " mem_addr"},  mem_addr, v.maddr);
        chk({tag, " mem_wdata"}, mem_wdata, v.mwdata);
        chk({tag, " rvalid"},    32'({instr_rvalid, data_rvalid, cust_rvalid}), 32'(v.rv));
        chk({tag, " err"},       32'({instr_err, data_err}), 32'(v.err));
        chk({tag, " instr_rdata"}, instr_rdata, v.rv[2] ? v.rdata : 32'h0);
        chk({tag, " data_rdata"},  data_rdata,  v.rv[1] ? v.rdata : 32'h0);
        chk({tag, " cust_rdata"},  cust_rdata,  v.rv[0] ? v.rdata : 32'h0);
        @(negedge clk);
    endtask

    vec_t tbl[12];

    initial begin
        rst_n = 1'b0;
        instr_req = 0; instr_addr = '0;
        data_req = 0; data_we = 0; data_be = '0; data_addr = '0; data_wdata = '0;
        cust_req = 0; cust_we = 0; cust_addr = '0; cust_wdata = '0;

        //          ireq iaddr          dreq we be    daddr          dwdata         creq we caddr          cwdata         gnt     mreq we be    maddr          mwdata         rv      err    rdata
        tbl[0]  = mkv(0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         3'b000, 0, 0, 4'h0, 32'h0,         32'h0,         3'b000, 2'b00, 32'h0);
        tbl[1]  = mkv(1, 32'h80,        0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         3'b100, 1, 0, 4'hF, 32'h80,        32'h0,         3'b000, 2'b00, 32'h0);
        tbl[2]  = mkv(0, 32'h0,         1, 1, 4'h3, 32'h100,       32'hDEADBEEF,  0, 0, 32'h0,         32'h0,         3'b010, 1, 1, 4'h3, 32'h100,       32'hDEADBEEF,  3'b100, 2'b00, 32'h5A5A0080);
        tbl[3]  = mkv(0, 32'h0,         1, 0, 4'hF, 32'h0004_0000, 32'h0,         0, 0, 32'h0,         32'h0,         3'b010, 0, 0, 4'h0, 32'h0,         32'h0,         3'b010, 2'b00, 32'h5A5A0100);
        tbl[4]  = mkv(0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         1, 1, 32'h200,       32'hCAFEF00D,  3'b001, 1, 1, 4'hF, 32'h200,       32'hCAFEF00D,  3'b010, 2'b01, 32'h0);
        tbl[5]  = mkv(0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         3'b000, 0, 0, 4'h0, 32'h0,         32'h0,         3'b001, 2'b00, 32'h5A5A0200);
        tbl[6]  = mkv(1, 32'h10,        1, 0, 4'hF, 32'h20,        32'h0,         1, 0, 32'h30,        32'h0,         3'b100, 1, 0, 4'hF, 32'h10,        32'h0,         3'b000, 2'b00, 32'h0);
        tbl[7]  = mkv(0, 32'h0,         1, 0, 4'hF, 32'h20,        32'h0,         1, 0, 32'h30,        32'h0,         3'b010, 1, 0, 4'hF, 32'h20,        32'h0,         3'b100, 2'b00, 32'h5A5A0010);
        tbl[8]  = mkv(0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 32'h30,        32'h0,         3'b001, 1, 0, 4'hF, 32'h30,        32'h0,         3'b010, 2'b00, 32'h5A5A0020);
        tbl[9]  = mkv(0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         3'b000, 0, 0, 4'h0, 32'h0,         32'h0,         3'b001, 2'b00, 32'h5A5A0030);
        tbl[10] = mkv(0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         1, 0, 32'h0008_0000, 32'h0,         3'b001, 0, 0, 4'h0, 32'h0,         32'h0,         3'b000, 2'b00, 32'h0);
        tbl[11] = mkv(0, 32'h0,         0, 0, 4'h0, 32'h0,         32'h0,         0, 0, 32'h0,         32'h0,         3'b000, 0, 0, 4'h0, 32'h0,         32'h0,         3'b001, 2'b00, 32'h0);

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run(tbl[i], $sformatf("tbl%0d", i));
        end

        // Data starved behind continuous fetch: denied 4 cycles, promoted on the 5th.
        for (int c = 0; c < 5; c++) begin
            if (c < 4)
                run(mkv(1, 32'h40, 1, 0, 4'hF, 32'h44, 32'h0, 0, 0, 32'h0, 32'h0,
                        3'b100, 1, 0, 4'hF, 32'h40, 32'h0, c == 0 ? 3'b000 : 3'b100, 2'b00,
                        c == 0 ? 32'h0 : 32'h5A5A0040), $sformatf("starve_d%0d", c));
            else
                run(mkv(1, 32'h40, 1, 0, 4'hF, 32'h44, 32'h0, 0, 0, 32'h0, 32'h0,
                        3'b010, 1, 0, 4'hF, 32'h44, 32'h0, 3'b100, 2'b00, 32'h5A5A0040), "starve_d4");
        end
        run(mkv(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                3'b100, 1, 0, 4'hF, 32'h40, 32'h0, 3'b010, 2'b00, 32'h5A5A0044), "starve_d5");
        run(mkv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                3'b000, 0, 0, 4'h0, 32'h0, 32'h0, 3'b100, 2'b00, 32'h5A5A0040), "starve_idle");

        // Data and cust both starved: data wins first, cust (still promoted) next, then fetch.
        for (int c = 0; c < 4; c++) begin
            run(mkv(1, 32'h40, 1, 0, 4'hF, 32'h48, 32'h0, 1, 0, 32'h4C, 32'h0,
                    3'b100, 1, 0, 4'hF, 32'h40, 32'h0, c == 0 ? 3'b000 : 3'b100, 2'b00,
                    c == 0 ? 32'h0 : 32'h5A5A0040), $sformatf("both_%0d", c));
        end
        run(mkv(1, 32'h40, 1, 0, 4'hF, 32'h48, 32'h0, 1, 0, 32'h4C, 32'h0,
                3'b010, 1, 0, 4'hF, 32'h48, 32'h0, 3'b100, 2'b00, 32'h5A5A0040), "both_4");
        run(mkv(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h4C, 32'h0,
                3'b001, 1, 0, 4'hF, 32'h4C, 32'h0, 3'b010, 2'b00, 32'h5A5A0048), "both_5");
        run(mkv(1, 32'h40, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                3'b100, 1, 0, 4'hF, 32'h40, 32'h0, 3'b001, 2'b00, 32'h5A5A004C), "both_6");
        run(mkv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                3'b000, 0, 0, 4'h0, 32'h0, 32'h0, 3'b100, 2'b00, 32'h5A5A0040), "both_idle");

        // Reset lands on an in-flight cust read: response must be dropped.
        run(mkv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1, 0, 32'h60, 32'h0,
                3'b001, 1, 0, 4'hF, 32'h60, 32'h0, 3'b000, 2'b00, 32'h0), "rst_cust");
        rst_n = 1'b0;
        run(mkv(1, 32'h64, 1, 1, 4'hF, 32'h68, 32'h1234, 1, 0, 32'h60, 32'h0,
                3'b000, 0, 0, 4'h0, 32'h0, 32'h0, 3'b000, 2'b00, 32'h0), "rst_low0");
        run(mkv(1, 32'h64, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                3'b000, 0, 0, 4'h0, 32'h0, 32'h0, 3'b000, 2'b00, 32'h0), "rst_low1");
        rst_n = 1'b1;
        run(mkv(1, 32'h64, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                3'b100, 1, 0, 4'hF, 32'h64, 32'h0, 3'b000, 2'b00, 32'h0), "rst_rel0");
        run(mkv(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0,
                3'b000, 0, 0, 4'h0, 32'h0, 32'h0, 3'b100, 2'b00, 32'h5A5A0064), "rst_rel1");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
